// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
//   uart_rx_state_t   receiver FSM state encoding
//   UART_IDLE_LEVEL   level of an idle line / stop bit
//   UART_START_LEVEL  level of a start bit
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      RECOVER
   } uart_rx_state_t;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
//   clk    in  clock
//   reset  in  synchronous active-high reset; both flops reset to the idle level
//   d_i    in  asynchronous serial input
//   q_o    out synchronized serial line
module uart_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Resetting to the idle level keeps the receiver from seeing a false start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= UART_IDLE_LEVEL;
         sync_q <= UART_IDLE_LEVEL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : uart_sync

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 1 start bit, WIDTH data bits LSB first, 1 stop bit.
//   clk       in  clock
//   reset     in  synchronous active-high reset
//   dataIn    in  asynchronous serial line, idles high
//   dataOut   out last received word, stable while valid is high
//   valid     out word available on dataOut
//   ack       in  consumer accepts the word (only meaningful while valid is high)
//   frameErr  out one-cycle pulse when the stop bit is sampled low
//   overrun   out one-cycle pulse when a word completes while valid is high and ack is low
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dataIn,
   output logic [WIDTH-1:0] dataOut,
   output logic             valid,
   input  logic             ack,
   output logic             frameErr,
   output logic             overrun
);

   localparam int unsigned H     = OVERSAMPLE / 2;
   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned IDX_W = $clog2(WIDTH) + 1;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   logic                 rxs;
   uart_rx_state_t       state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     idx_q;
   logic [WIDTH-1:0]     shreg_q;
   logic [WIDTH-1:0]     data_q;
   logic                 valid_q;
   logic                 frame_err_q;
   logic                 overrun_q;

   uart_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (dataIn),
      .q_o   (rxs)
   );

   // Receiver FSM, bit timing counters, shift register and output handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;

         // Consumption; a completing word in STOP overrides this below.
         if (valid_q && ack) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (rxs == UART_START_LEVEL) begin
                  state_q <= START;
                  cnt_q   <= '0;
               end
            end

            // Re-check the start bit at its midpoint to reject glitches.
            START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q <= '0;
                  if (rxs == UART_START_LEVEL) begin
                     state_q <= DATA;
                     idx_q   <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            // Sample each data bit one full bit time after the previous midpoint.
            DATA: begin
               if (cnt_q == CNT_FULL) begin
                  cnt_q   <= '0;
                  shreg_q <= (shreg_q >> 1) | (WIDTH'(rxs) << (WIDTH - 1));
                  idx_q   <= idx_q + IDX_W'(1);
                  if (idx_q == IDX_LAST) begin
                     state_q <= STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            STOP: begin
               if (cnt_q == CNT_FULL) begin
                  cnt_q <= '0;
                  if (rxs == UART_IDLE_LEVEL) begin
                     state_q <= IDLE;
                     if (!valid_q || ack) begin
                        data_q  <= shreg_q;
                        valid_q <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= RECOVER;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            // Hold off until the line returns idle so a break cannot start a frame.
            RECOVER: begin
               if (rxs == UART_IDLE_LEVEL) begin
                  state_q <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign dataOut  = data_q;
   assign valid    = valid_q;
   assign frameErr = frame_err_q;
   assign overrun  = overrun_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (WIDTH=8, OVERSAMPLE=16).
module tb_uart_rx;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       dataIn;
   logic [7:0] dataOut;
   logic       valid;
   logic       ack;
   logic       frameErr;
   logic       overrun;

   always #5 clk = ~clk;

   uart_rx #(.WIDTH(8), .OVERSAMPLE(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .dataIn   (dataIn),
      .dataOut  (dataOut),
      .valid    (valid),
      .ack      (ack),
      .frameErr (frameErr),
      .overrun  (overrun)
   );

   int unsigned cyc = 0;
   int unsigned fe_cnt = 0;
   int unsigned ov_cnt = 0;
   int unsigned both_cnt = 0;
   int unsigned rise_cyc = 0;
   logic        valid_prev = 1'b0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  last_word;
   int unsigned t0;
   int unsigned fe_base;
   int unsigned ov_base;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse and valid-rise monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (frameErr) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frameErr && overrun) both_cnt++;
      if (valid && !valid_prev) rise_cyc = cyc;
      valid_prev = valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Drives one 10-bit frame, 16 clk per bit; optional ack on the word-completion edge.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit ack_done,
                             output int unsigned start_cyc);
      logic [9:0] bits;
      bits = {stop_bit, d, 1'b0};
      @(negedge clk);
      start_cyc = cyc;
      for (int i = 0; i < 160; i++) begin
         if (i > 0) @(negedge clk);
         dataIn = bits[i / 16];
         ack    = ack_done && (i == 154);
      end
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 32'(0), 32'(1));
      end else begin
         e = exp_q.pop_front();
         last_word = e;
         check(tag, 32'(dataOut), 32'(e));
      end
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   initial begin
      // 1: reset state
      reset  = 1'b1;
      dataIn = 1'b1;
      ack    = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_dataOut", 32'(dataOut), 32'(0));
      check("rst_valid", 32'(valid), 32'(0));
      check("rst_frameErr", 32'(frameErr), 32'(0));
      check("rst_overrun", 32'(overrun), 32'(0));
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // 2: basic frame and latency
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0, t0);
      check("a5_valid", 32'(valid), 32'(1));
      pop_check("a5_data");
      check("a5_latency", rise_cyc - t0, 32'(155));
      ack_pulse();
      check("a5_ack_clears", 32'(valid), 32'(0));

      // 3: short glitch is rejected
      @(negedge clk);
      dataIn = 1'b0;
      repeat (4) @(negedge clk);
      dataIn = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch_state", 32'(dut.state_q), 32'(IDLE));
      check("glitch_valid", 32'(valid), 32'(0));
      check("glitch_fe", fe_cnt, 32'(0));
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, 1'b0, t0);
      check("3c_valid", 32'(valid), 32'(1));
      pop_check("3c_data");
      ack_pulse();

      // 4: framing error with held-low line
      send_frame(8'h55, 1'b0, 1'b0, t0);
      repeat (40) @(negedge clk);
      check("fe_count", fe_cnt, 32'(1));
      check("fe_valid", 32'(valid), 32'(0));
      check("fe_recover", 32'(dut.state_q), 32'(RECOVER));
      dataIn = 1'b1;
      repeat (5) @(negedge clk);
      check("fe_idle", 32'(dut.state_q), 32'(IDLE));
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 1'b0, t0);
      pop_check("81_data");
      check("81_fe_stable", fe_cnt, 32'(1));
      ack_pulse();

      // 5: overrun without ack, then ack on the completion edge
      ov_base = ov_cnt;
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1, 1'b0, t0);
      pop_check("12_data");
      send_frame(8'h34, 1'b1, 1'b0, t0);
      check("ovr_count", ov_cnt, ov_base + 1);
      check("ovr_data_held", 32'(dataOut), 32'(last_word));
      check("ovr_valid", 32'(valid), 32'(1));
      ack_pulse();
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1, 1'b0, t0);
      pop_check("12b_data");
      exp_q.push_back(8'h34);
      send_frame(8'h34, 1'b1, 1'b1, t0);
      pop_check("34_ack_data");
      check("34_ack_valid", 32'(valid), 32'(1));
      check("34_ack_no_ovr", ov_cnt, ov_base + 1);

      // 6: reset in the middle of a frame
      fe_base = fe_cnt;
      @(negedge clk);
      for (int i = 0; i < 60; i++) begin
         if (i > 0) @(negedge clk);
         dataIn = (i < 16) ? 1'b0 : 1'b1;
      end
      check("mid_state_data", 32'(dut.state_q), 32'(DATA));
      reset  = 1'b1;
      dataIn = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("mid_rst_dataOut", 32'(dataOut), 32'(0));
      check("mid_rst_valid", 32'(valid), 32'(0));
      check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
      repeat (20) @(negedge clk);
      check("mid_no_word", 32'(valid), 32'(0));
      exp_q.push_back(8'hF0);
      send_frame(8'hF0, 1'b1, 1'b0, t0);
      pop_check("f0_data");
      check("f0_valid", 32'(valid), 32'(1));
      check("f0_no_fe", fe_cnt, fe_base);

      check("never_both", both_cnt, 32'(0));
      check("queue_empty", 32'(exp_q.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_uart_rx
